mux_sel_reg: RTL and testbench
==============================

Name: mux_sel_reg

Overview:
Parametrised, registered N-channel, W-bit channel selector with a valid/ready output stage. It is the next generation of the team's combinational 6-to-1 select mux. It adds three selection modes: direct select, timed scan and valid-driven round-robin. It also gives per-channel consume acknowledges. It sits between multiple producer units and a single consumer, for example a display/ALU result path.

Parameters:
NCH, 6, number of input channels (2..16)
W, 8, data width per channel
DWELL, 4, scan-mode cycles per channel (1..255)
SW, $clog2(NCH), select/pointer width (derived, not overridable)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  NCH*W  packed channel data, channel k at [k*W +: W]
in_valid  in  NCH  per-channel data valid
in_ready  out  NCH  one-hot: channel k consumed this cycle
mode  in  2  00 direct, 01 scan, 10 round-robin, 11 hold (no capture)
sel  in  SW  channel index for direct mode
out_data  out  W  registered selected data
out_ch  out  SW  channel index of out_data
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data
sel_err  out  1  one-cycle pulse: direct-mode sel >= NCH

Behaviour:
- Reset (async, rst_n=0): out_data=0, out_ch=0, out_valid=0, sel_err=0, in_ready=0, ptr=0, dwell_cnt=0, rr_ptr=0. Release is synchronous to clk.
- Slot free = !out_valid || out_ready. A capture happens only when the slot is free and a grant exists. Otherwise out_* holds its value.
- Capture: out_data<=in_data[g], out_ch<=g, out_valid<=1. in_ready[g]=1 combinationally in the same cycle. in_ready is never asserted without a capture.
- No capture and out_ready=1: out_valid<=0. Capture and out_ready in the same cycle: new word loads, out_valid stays 1.
- Latency: input to out_data is 1 cycle.
- Direct (00): g=sel if sel<NCH and in_valid[sel]. If sel>=NCH: no grant, and sel_err=1 for that cycle (registered, next-cycle pulse) regardless of the slot.
- Scan (01): g=ptr if in_valid[ptr].
  - dwell_cnt increments every cycle in scan mode.
  - At dwell_cnt==DWELL-1: dwell_cnt<=0 and ptr<=ptr+1, wrapping NCH-1 to 0.
  - A channel may be captured several times within its dwell window.
- Round-robin (10): g = first k with in_valid[k], searching rr_ptr, rr_ptr+1, … modulo NCH.
  - On capture, rr_ptr<=g+1, wrapping NCH-1 to 0.
  - If no valid channel exists, there is no grant and rr_ptr is unchanged.
- Hold (11): no grants. The output stage still drains on out_ready. Pointers are frozen.
- Mode change (mode differs from the previous cycle): dwell_cnt<=0. ptr and rr_ptr are retained. The grant in the change cycle uses the new mode.
- Stall: while out_valid && !out_ready, out_data and out_ch are stable, in_ready=0, and no pointer advances except the scan timer (scan stays time-based).
- in_valid is sampled only at capture. Deasserting in_valid without an in_ready pulse is legal and means the word is dropped.

Decomposition:
- Shared package: mode encodings MODE_DIRECT=2'b00, MODE_SCAN=2'b01, MODE_RR=2'b10, MODE_HOLD=2'b11. Also a channel-index width helper function.
- One natural sub-module: rr_pick, a combinational rotating priority encoder. Inputs are NCH-bit valid and an SW-bit start pointer. Outputs are the grant index and a grant flag.
- Everything else (output register, timer, pointers) stays in the top.

Test Plan:
- Reset: hold rst_n=0 with all inputs active -> every output 0. Assert rst_n=0 asynchronously mid-stream -> outputs clear before the next edge.
- Direct: NCH=6, W=8, mode=00, sel=3, in_data ch3=8'hA5, in_valid=6'b001000, out_ready=1 -> next cycle out_data=A5, out_ch=3, out_valid=1, in_ready=6'b001000 in the capture cycle. Then sel=6 -> sel_err pulses once, out_valid drops.
- Stall: with out_valid=1, set out_ready=0 for 5 cycles while ch3 changes to 8'h11 -> out_data stays A5 and in_ready=0. Raise out_ready -> 11 loads the next cycle, with out_valid never deasserting.
- Scan: DWELL=4, all in_valid=1, ch k data=k -> out_ch sequence 0,0,0,0,1,1,1,1,… up to 5, then wraps to 0 at cycle 24.
- Round-robin: in_valid=6'b100101, out_ready=1 -> grants 0,2,5,0,2,5. Clearing bit 2 after the first grant -> 0,5,0.
- Mode switch: from scan at dwell_cnt=2 switch to hold for 3 cycles, then back to scan -> no in_ready during hold, ptr unchanged, and a full 4-cycle dwell restarts.

Source files
------------

// File: rtl/mux_sel_reg_pkg.sv
// Shared definitions for the registered channel selector.
// Mode encodings and the channel-index width helper.
package mux_sel_reg_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_SCAN   = 2'b01,
        MODE_RR     = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    // Index width for n channels, never narrower than one bit.
    function automatic int chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_sel_reg_rr_pick.sv
// Rotating priority encoder: first valid channel at or after start_i.
// Purely combinational; start_i is always below NCH.
module rr_pick
    import mux_sel_reg_pkg::*;
#(
    parameter  int NCH = 6,
    localparam int SW  = chw(NCH)
) (
    input  logic [NCH-1:0] vld_i,
    input  logic [SW-1:0]  start_i,
    output logic [SW-1:0]  idx_o,
    output logic           gnt_o
);

    // Descending walk so the candidate closest to start_i wins last.
    always_comb begin
        gnt_o = 1'b0;
        idx_o = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (vld_i[(int'(start_i) + i) % NCH]) begin
                gnt_o = 1'b1;
                idx_o = SW'((int'(start_i) + i) % NCH);
            end
        end
    end

endmodule

// File: rtl/mux_sel_reg.sv
// Registered N-channel selector with direct, scan and round-robin modes.
// One-cycle capture into a valid/ready output register with per-channel acks.
module mux_sel_reg
    import mux_sel_reg_pkg::*;
#(
    parameter  int NCH   = 6,
    parameter  int W     = 8,
    parameter  int DWELL = 4,
    localparam int SW    = chw(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH*W-1:0] in_data,
    input  logic [NCH-1:0] in_valid,
    output logic [NCH-1:0] in_ready,
    input  logic [1:0]     mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           sel_err
);

    localparam int NP = 1 << SW;

    logic [W-1:0]    out_data_q, out_data_d;
    logic [SW-1:0]   out_ch_q, out_ch_d;
    logic            out_valid_q, out_valid_d;
    logic            sel_err_q, sel_err_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]      dwell_q, dwell_d;
    logic [1:0]      mode_q;
    logic            mode_vld_q;

    logic [NP-1:0]   vld_pad;
    logic [NP*W-1:0] data_pad;
    logic [SW-1:0]   rr_idx, g;
    logic            rr_gnt, grant, cap, sel_ok, chg;

    function automatic logic [SW-1:0] nxt(input logic [SW-1:0] p);
        return (32'(p) == NCH - 1) ? '0 : p + 1'b1;
    endfunction

    assign vld_pad  = NP'(in_valid);
    assign data_pad = (NP*W)'(in_data);

    rr_pick #(.NCH(NCH)) u_rr_pick (
        .vld_i   (in_valid),
        .start_i (rr_ptr_q),
        .idx_o   (rr_idx),
        .gnt_o   (rr_gnt)
    );

    always_comb begin
        sel_ok = 32'(sel) < NCH;
        grant  = 1'b0;
        g      = '0;
        unique case (mode_e'(mode))
            MODE_DIRECT: begin
                g     = sel;
                grant = sel_ok && vld_pad[sel];
            end
            MODE_SCAN: begin
                g     = ptr_q;
                grant = vld_pad[ptr_q];
            end
            MODE_RR: begin
                g     = rr_idx;
                grant = rr_gnt;
            end
            MODE_HOLD: grant = 1'b0;
        endcase
        // No acknowledge may escape while the block is held in reset.
        cap      = rst_n && grant && (!out_valid_q || out_ready);
        in_ready = cap ? (NCH'(1) << g) : '0;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (cap) begin
            out_data_d  = data_pad[int'(g)*W +: W];
            out_ch_d    = g;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        sel_err_d = (mode == MODE_DIRECT) && !sel_ok;

        chg      = mode_vld_q && (mode != mode_q);
        dwell_d  = dwell_q;
        ptr_d    = ptr_q;
        rr_ptr_d = rr_ptr_q;
        // Scan timer keeps running through output stalls.
        if (chg) begin
            dwell_d = '0;
        end else if (mode == MODE_SCAN) begin
            if (32'(dwell_q) == DWELL - 1) begin
                dwell_d = '0;
                ptr_d   = nxt(ptr_q);
            end else begin
                dwell_d = dwell_q + 8'd1;
            end
        end
        if (mode == MODE_RR && cap) begin
            rr_ptr_d = nxt(g);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            ptr_q       <= '0;
            rr_ptr_q    <= '0;
            dwell_q     <= '0;
            mode_q      <= MODE_DIRECT;
            mode_vld_q  <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            ptr_q       <= ptr_d;
            rr_ptr_q    <= rr_ptr_d;
            dwell_q     <= dwell_d;
            mode_q      <= mode;
            mode_vld_q  <= 1'b1;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_sel_reg.sv
// Directed bench for mux_sel_reg (NCH=6, W=8, DWELL=4).
// Hand-computed vectors for reset, direct, stall, scan, hold and round-robin.
module tb_mux_sel_reg;

    localparam int NCH   = 6;
    localparam int W     = 8;
    localparam int DWELL = 4;
    localparam int SW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_ready;
    logic [1:0]       mode;
    logic [SW-1:0]    sel;
    logic [W-1:0]     out_data;
    logic [SW-1:0]    out_ch;
    logic             out_valid;
    logic             out_ready;
    logic             sel_err;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mux_sel_reg #(.NCH(NCH), .W(W), .DWELL(DWELL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]     sb_exp [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    logic [5:0]     rr_v   [9] = '{6'b100101, 6'b100101, 6'b100101,
                                   6'b100101, 6'b100101, 6'b100101,
                                   6'b100101, 6'b100001, 6'b100001};
    logic [2:0]     rr_g   [9] = '{3'd0, 3'd2, 3'd5, 3'd0, 3'd2, 3'd5,
                                   3'd0, 3'd5, 3'd0};

    initial begin
        rst_n     = 1'b0;
        mode      = 2'b00;
        sel       = 3'd3;
        in_valid  = '1;
        out_ready = 1'b1;
        for (int k = 0; k < NCH; k++) in_data[k*W +: W] = 8'hF0 + 8'(k);
        tick();
        tick();
        check("rst_data", out_data, 0);
        check("rst_ch", out_ch, 0);
        check("rst_valid", out_valid, 0);
        check("rst_selerr", sel_err, 0);
        check("rst_ready", in_ready, 0);

        in_data          = '0;
        in_data[3*W +: W] = 8'hA5;
        in_valid         = 6'b001000;
        rst_n            = 1'b1;
        #1 check("dir_ready", in_ready, 6'b001000);
        tick();
        check("dir_data", out_data, 8'hA5);
        check("dir_ch", out_ch, 3);
        check("dir_valid", out_valid, 1);

        sel = 3'd6;
        #1 check("err_ready", in_ready, 0);
        tick();
        check("err_pulse", sel_err, 1);
        check("err_drain", out_valid, 0);
        sel = 3'd3;
        tick();
        check("err_once", sel_err, 0);
        check("recap_valid", out_valid, 1);
        check("recap_data", out_data, 8'hA5);

        out_ready         = 1'b0;
        in_data[3*W +: W] = 8'h11;
        for (int i = 0; i < 5; i++) begin
            #1 check("stall_ready", in_ready, 0);
            tick();
            check("stall_data", out_data, 8'hA5);
            check("stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1 check("unstall_ready", in_ready, 6'b001000);
        tick();
        check("unstall_data", out_data, 8'h11);
        check("unstall_valid", out_valid, 1);

        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_ch", out_ch, 0);
        check("arst_ready", in_ready, 0);

        mode     = 2'b01;
        in_valid = '1;
        for (int k = 0; k < NCH; k++) in_data[k*W +: W] = 8'(k);
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            tick();
            check("scan_ch", out_ch, ((i - 1) / 4) % 6);
            check("scan_data", out_data, ((i - 1) / 4) % 6);
        end

        mode = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_ready", in_ready, 0);
            tick();
            check("hold_drain", out_valid, 0);
        end
        mode = 2'b01;
        #1 check("scanback_ready", in_ready, 6'b000001);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("scanback_ch", out_ch, sb_exp[i]);
        end

        mode = 2'b10;
        for (int i = 0; i < 9; i++) begin
            in_valid = rr_v[i];
            #1 check("rr_ready", in_ready, 6'(1) << rr_g[i]);
            tick();
            check("rr_ch", out_ch, rr_g[i]);
            check("rr_valid", out_valid, 1);
        end
        in_valid = '0;
        #1 check("rr_none_ready", in_ready, 0);
        tick();
        check("rr_none_drain", out_valid, 0);
        in_valid = '1;
        #1 check("rr_keep_ready", in_ready, 6'b000010);
        tick();
        check("rr_keep_ch", out_ch, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
